uart_cmd_responder: RTL
=======================

# uart_cmd_responder

Byte-level command responder on the far side of the UART link. Parses host command frames from the UART receiver's parallel output, reads or writes an internal register file, and sends response bytes to the UART transmitter's parallel input. Also exports the link configuration (parity enable, parity type, prescale) held in the register file, so the host can reconfigure the transceiver over the link.

## Interface
- DATA_WIDTH, 8, register and UART byte width
- ADDR_WIDTH, 4, register-file address width; depth is 2**ADDR_WIDTH
- TIMEOUT_CYCLES, 4096, idle cycles mid-frame before the frame is abandoned; must be ≥ 2
- CLK  in  1  responder clock (RX/TX parallel interfaces are already in this domain)
- RST  in  1  asynchronous, active-high reset
- RX_P_DATA  in  DATA_WIDTH  received byte; valid only when RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte
- TX_BUSY  in  1  transmitter busy; a new byte must not be offered while high
- TX_P_DATA  out  DATA_WIDTH  response byte (registered)
- TX_D_VLD  out  1  one-cycle pulse that offers TX_P_DATA (registered)
- CFG_PAR_EN  out  1  REG2[0]
- CFG_PAR_TYP  out  1  REG2[1]
- CFG_PRESCALE  out  6  REG2[7:2]

## Operation
- Register file: 2**ADDR_WIDTH × DATA_WIDTH. Reset value is 0x00 for every entry except REG2, which resets to 0x81 (prescale 32, parity enabled, even). The CFG_* outputs are driven combinationally from REG2.
- Frames:
  - Write = 0xAA, addr, data.
  - Read = 0xBB, addr.
  - Address byte: only the low ADDR_WIDTH bits are used; upper bits are ignored (aliasing).
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RESP.
  - IDLE: on RX_D_VLD, 0xAA → WR_ADDR, 0xBB → RD_ADDR; any other byte is ignored and the FSM stays in IDLE.
  - WR_ADDR: on byte, latch the address → WR_DATA.
  - WR_DATA: on byte, write reg[addr] → IDLE.
  - RD_ADDR: on byte, load TX_P_DATA ← reg[addr] → RESP.
  - RESP: when TX_BUSY=0, pulse TX_D_VLD → IDLE. While TX_BUSY=1, stay in RESP with TX_D_VLD=0.
- RX_D_VLD in RESP is ignored (byte dropped).
- Timeout counter:
  - Runs only in WR_ADDR, WR_DATA and RD_ADDR.
  - Cleared on entering any of those states and on every accepted byte.
  - When TIMEOUT_CYCLES consecutive cycles pass without RX_D_VLD, the FSM returns to IDLE. No write is performed and no response is sent.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Simultaneous byte and timeout expiry: the byte wins and is processed normally.
- Reset at any point, including mid-frame or in RESP: FSM → IDLE, TX_D_VLD=0, TX_P_DATA=0x00, counter=0, register file restored to its reset values.

## Timing
- Reset values: TX_D_VLD=0, TX_P_DATA=0x00, CFG_PAR_EN=1, CFG_PAR_TYP=0, CFG_PRESCALE=32.
- Write: data byte sampled at edge E → register updated at E; a read of it in any later frame returns the new value. CFG_* outputs change right after E when REG2 is written.
- Read:
  - Address byte sampled at edge E → TX_P_DATA valid from E.
  - If TX_BUSY=0 at edge E+1, TX_D_VLD is high from E+1 to E+2.
  - Otherwise the pulse starts at the first edge that samples TX_BUSY=0.
- TX_D_VLD is never high for two consecutive cycles.
- TX_P_DATA holds its value until the next response is loaded.
- Back-to-back frames: a new command byte is accepted in the first IDLE cycle after the previous frame completes.

## Configuration
- UART_CMD_WR_ACK_EN defined: a completed write goes WR_DATA → RESP with TX_P_DATA=0xAC. The ack is sent under the same TX_BUSY handshake and timing as a read response.
- UART_CMD_WR_ACK_EN undefined: writes produce no TX traffic; WR_DATA → IDLE.

## Test plan
- Reset asserted asynchronously mid-frame → outputs immediately at reset values; CFG_* = 1/0/32; the next 0xBB,0x02 returns 0x81.
- Frame 0xAA,0x05,0x3C then 0xBB,0x05 (TX_BUSY=0) → exactly one TX_D_VLD pulse with TX_P_DATA=0x3C, one cycle after the address edge.
- Read with TX_BUSY held high for 10 cycles → no pulse while busy; a single pulse on the first edge after TX_BUSY falls. A byte received during the wait is dropped.
- TIMEOUT_CYCLES=16: 0xAA,0x07 then 16 idle cycles → IDLE, REG7 unchanged. Then 0xBB,0x07 → 0x00. A byte arriving on exactly the 16th cycle is accepted.
- 0x55 in IDLE → ignored, no TX. Then 0xAA,0xF2,0x04 → REG2=0x04 (alias of 0xF2 to address 2); CFG_PAR_EN=0, CFG_PAR_TYP=0, CFG_PRESCALE=1.
- With UART_CMD_WR_ACK_EN: write 0xAA,0x01,0x99 → one pulse with TX_P_DATA=0xAC. Without the macro → no pulse.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: parses host command frames (write 0xAA,addr,data /
// read 0xBB,addr) from the UART receiver, accesses a small register file and
// returns read data to the UART transmitter. REG2 carries the link config.
// Optional feature macro: UART_CMD_WR_ACK_EN (write completes with a 0xAC ack).
module uart_cmd_responder #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  CFG_PAR_EN,
    output logic                  CFG_PAR_TYP,
    output logic [5:0]            CFG_PRESCALE
);

    localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] REG2_RV = DATA_WIDTH'(8'h81);
`ifdef UART_CMD_WR_ACK_EN
    localparam logic [DATA_WIDTH-1:0] WR_ACK  = DATA_WIDTH'(8'hAC);
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    wr_en_c;
    logic                    timeout_c;
    logic [ADDR_WIDTH-1:0]   rx_addr_c;
    logic [DATA_WIDTH-1:0]   regs_q [DEPTH];

    assign rx_addr_c = RX_P_DATA[ADDR_WIDTH-1:0];
    // Expiry only counts when no byte arrives this cycle: a byte always wins.
    assign timeout_c = (cnt_q == CNT_LAST) && !RX_D_VLD;

    // Next-state, timeout counter and response-register logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = '0;
        tx_data_d = tx_data_q;
        tx_vld_d  = 1'b0;
        wr_en_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_WR)      state_d = ST_WR_ADDR;
                    else if (RX_P_DATA == CMD_RD) state_d = ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                if (RX_D_VLD) begin
                    addr_d  = rx_addr_c;
                    state_d = ST_WR_DATA;
                end else if (timeout_c) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_c = 1'b1;
`ifdef UART_CMD_WR_ACK_EN
                    tx_data_d = WR_ACK;
                    state_d   = ST_RESP;
`else
                    state_d   = ST_IDLE;
`endif
                end else if (timeout_c) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (RX_D_VLD) begin
                    tx_data_d = regs_q[rx_addr_c];
                    state_d   = ST_RESP;
                end else if (timeout_c) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                // Received bytes are dropped while a response is pending.
                if (!TX_BUSY) begin
                    tx_vld_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, address latch, counter and TX output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
        end
    end

    // Register file; REG2 resets to the default link configuration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= (i == 2) ? REG2_RV : '0;
            end
        end else if (wr_en_c) begin
            regs_q[addr_q] <= RX_P_DATA;
        end
    end

    assign TX_P_DATA    = tx_data_q;
    assign TX_D_VLD     = tx_vld_q;
    assign CFG_PAR_EN   = regs_q[2][0];
    assign CFG_PAR_TYP  = regs_q[2][1];
    assign CFG_PRESCALE = regs_q[2][7:2];

endmodule
